// File: rtl/reorder_buffer_pkg.sv
// Shared constants and tag/index helpers for the reorder buffer.
package reorder_buffer_pkg;

    localparam int ROB_SIZE = 16;
    localparam int TAG_W    = 5;
    localparam int IDX_W    = 4;

    localparam logic [TAG_W-1:0] NO_TAG     = '0;
    localparam logic [IDX_W:0]   FULL_COUNT = (IDX_W+1)'(ROB_SIZE);

    // Tags are entry index plus one so that tag 0 can mean "no producer".
    function automatic logic [TAG_W-1:0] idx_to_tag(input logic [IDX_W-1:0] idx);
        return {1'b0, idx} + 5'd1;
    endfunction

    function automatic logic [IDX_W-1:0] tag_to_idx(input logic [TAG_W-1:0] tag);
        logic [TAG_W-1:0] t;
        t = tag - 5'd1;
        return t[IDX_W-1:0];
    endfunction

    function automatic logic tag_in_range(input logic [TAG_W-1:0] tag);
        return (tag != NO_TAG) && (tag <= TAG_W'(ROB_SIZE));
    endfunction

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement queue: hands out rename tags, collects CDB results,
// commits one instruction per cycle and triggers rollback on a mispredict.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             en_signal_from_dispatcher,
    input  logic [4:0]       rd_from_dispatcher,
    input  logic             is_branch_from_dispatcher,
    input  logic             is_store_from_dispatcher,
    input  logic             pred_jump_from_dispatcher,
    input  logic [31:0]      alt_pc_from_dispatcher,
    output logic [TAG_W-1:0] Q_to_dispatcher,
    output logic             full_to_dispatcher,
    input  logic [TAG_W-1:0] Q1_from_dispatcher,
    input  logic [TAG_W-1:0] Q2_from_dispatcher,
    output logic             ready1_to_dispatcher,
    output logic             ready2_to_dispatcher,
    output logic [31:0]      V1_to_dispatcher,
    output logic [31:0]      V2_to_dispatcher,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_Q,
    input  logic [31:0]      cdb_V,
    input  logic             cdb_jump,
    output logic             commit_flag_to_regfile,
    output logic [4:0]       rd_to_regfile,
    output logic [TAG_W-1:0] Q_to_regfile,
    output logic [31:0]      V_to_regfile,
    output logic             commit_store_to_lsb,
    output logic             rollback_flag,
    output logic [31:0]      target_pc_to_if
);

    logic [ROB_SIZE-1:0] busy;
    logic                ready_q       [ROB_SIZE];
    logic [4:0]          rd_q          [ROB_SIZE];
    logic [31:0]         value_q       [ROB_SIZE];
    logic                is_branch_q   [ROB_SIZE];
    logic                is_store_q    [ROB_SIZE];
    logic                pred_jump_q   [ROB_SIZE];
    logic                actual_jump_q [ROB_SIZE];
    logic [31:0]         alt_pc_q      [ROB_SIZE];

    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;
    logic [IDX_W:0]   count;

    logic             full;
    logic             do_commit;
    logic             do_rollback;
    logic             do_alloc;
    logic             do_write;
    logic [IDX_W-1:0] cdb_idx;

    assign full               = (count == FULL_COUNT);
    assign full_to_dispatcher = full;
    assign Q_to_dispatcher    = idx_to_tag(tail);

    // Decide this cycle's commit, mispredict, allocation and CDB writeback.
    always_comb begin
        do_commit   = busy[head] && ready_q[head];
        do_rollback = do_commit && is_branch_q[head] &&
                      (actual_jump_q[head] != pred_jump_q[head]);
        do_alloc    = en_signal_from_dispatcher && !full && !rollback_flag;
        cdb_idx     = tag_to_idx(cdb_Q);
        do_write    = cdb_valid && !rollback_flag && tag_in_range(cdb_Q) && busy[cdb_idx];
    end

    // Operand lookup for the dispatcher, forwarding a same-cycle CDB result.
    always_comb begin
        ready1_to_dispatcher = 1'b0;
        V1_to_dispatcher     = '0;
        ready2_to_dispatcher = 1'b0;
        V2_to_dispatcher     = '0;
        if (Q1_from_dispatcher == NO_TAG) begin
            ready1_to_dispatcher = 1'b1;
        end else if (cdb_valid && cdb_Q == Q1_from_dispatcher) begin
            ready1_to_dispatcher = 1'b1;
            V1_to_dispatcher     = cdb_V;
        end else if (tag_in_range(Q1_from_dispatcher)) begin
            ready1_to_dispatcher = ready_q[tag_to_idx(Q1_from_dispatcher)];
            V1_to_dispatcher     = value_q[tag_to_idx(Q1_from_dispatcher)];
        end
        if (Q2_from_dispatcher == NO_TAG) begin
            ready2_to_dispatcher = 1'b1;
        end else if (cdb_valid && cdb_Q == Q2_from_dispatcher) begin
            ready2_to_dispatcher = 1'b1;
            V2_to_dispatcher     = cdb_V;
        end else if (tag_in_range(Q2_from_dispatcher)) begin
            ready2_to_dispatcher = ready_q[tag_to_idx(Q2_from_dispatcher)];
            V2_to_dispatcher     = value_q[tag_to_idx(Q2_from_dispatcher)];
        end
    end

    // Queue state and registered commit/rollback outputs; pulses drop every cycle without a commit.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head                   <= '0;
            tail                   <= '0;
            count                  <= '0;
            busy                   <= '0;
            commit_flag_to_regfile <= 1'b0;
            rd_to_regfile          <= '0;
            Q_to_regfile           <= '0;
            V_to_regfile           <= '0;
            commit_store_to_lsb    <= 1'b0;
            rollback_flag          <= 1'b0;
            target_pc_to_if        <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                ready_q[i]       <= 1'b0;
                rd_q[i]          <= '0;
                value_q[i]       <= '0;
                is_branch_q[i]   <= 1'b0;
                is_store_q[i]    <= 1'b0;
                pred_jump_q[i]   <= 1'b0;
                actual_jump_q[i] <= 1'b0;
                alt_pc_q[i]      <= '0;
            end
        end else begin
            commit_flag_to_regfile <= 1'b0;
            commit_store_to_lsb    <= 1'b0;
            rollback_flag          <= 1'b0;
            if (rdy_in) begin
                if (do_commit) begin
                    commit_flag_to_regfile <= 1'b1;
                    rd_to_regfile          <= rd_q[head];
                    Q_to_regfile           <= idx_to_tag(head);
                    V_to_regfile           <= value_q[head];
                    commit_store_to_lsb    <= is_store_q[head];
                end
                if (do_rollback) begin
                    rollback_flag   <= 1'b1;
                    target_pc_to_if <= alt_pc_q[head];
                    busy            <= '0;
                    head            <= '0;
                    tail            <= '0;
                    count           <= '0;
                end else begin
                    if (do_write) begin
                        ready_q[cdb_idx]       <= 1'b1;
                        value_q[cdb_idx]       <= cdb_V;
                        actual_jump_q[cdb_idx] <= cdb_jump;
                    end
                    if (do_commit) begin
                        busy[head] <= 1'b0;
                        head       <= head + 4'd1;
                    end
                    if (do_alloc) begin
                        busy[tail]        <= 1'b1;
                        ready_q[tail]     <= 1'b0;
                        rd_q[tail]        <= rd_from_dispatcher;
                        is_branch_q[tail] <= is_branch_from_dispatcher;
                        is_store_q[tail]  <= is_store_from_dispatcher;
                        pred_jump_q[tail] <= pred_jump_from_dispatcher;
                        alt_pc_q[tail]    <= alt_pc_from_dispatcher;
                        tail              <= tail + 4'd1;
                    end
                    case ({do_alloc, do_commit})
                        2'b10:   count <= count + 5'd1;
                        2'b01:   count <= count - 5'd1;
                        default: count <= count;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer with a queue-based reference model.
module tb_reorder_buffer;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        en_signal_from_dispatcher = 1'b0;
    logic [4:0]  rd_from_dispatcher = '0;
    logic        is_branch_from_dispatcher = 1'b0;
    logic        is_store_from_dispatcher = 1'b0;
    logic        pred_jump_from_dispatcher = 1'b0;
    logic [31:0] alt_pc_from_dispatcher = '0;
    logic [4:0]  Q_to_dispatcher;
    logic        full_to_dispatcher;
    logic [4:0]  Q1_from_dispatcher = '0;
    logic [4:0]  Q2_from_dispatcher = '0;
    logic        ready1_to_dispatcher, ready2_to_dispatcher;
    logic [31:0] V1_to_dispatcher, V2_to_dispatcher;
    logic        cdb_valid = 1'b0;
    logic [4:0]  cdb_Q = '0;
    logic [31:0] cdb_V = '0;
    logic        cdb_jump = 1'b0;
    logic        commit_flag_to_regfile;
    logic [4:0]  rd_to_regfile;
    logic [4:0]  Q_to_regfile;
    logic [31:0] V_to_regfile;
    logic        commit_store_to_lsb;
    logic        rollback_flag;
    logic [31:0] target_pc_to_if;

    int total = 0;
    int bad   = 0;

    reorder_buffer dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .en_signal_from_dispatcher(en_signal_from_dispatcher),
        .rd_from_dispatcher(rd_from_dispatcher),
        .is_branch_from_dispatcher(is_branch_from_dispatcher),
        .is_store_from_dispatcher(is_store_from_dispatcher),
        .pred_jump_from_dispatcher(pred_jump_from_dispatcher),
        .alt_pc_from_dispatcher(alt_pc_from_dispatcher),
        .Q_to_dispatcher(Q_to_dispatcher), .full_to_dispatcher(full_to_dispatcher),
        .Q1_from_dispatcher(Q1_from_dispatcher), .Q2_from_dispatcher(Q2_from_dispatcher),
        .ready1_to_dispatcher(ready1_to_dispatcher), .ready2_to_dispatcher(ready2_to_dispatcher),
        .V1_to_dispatcher(V1_to_dispatcher), .V2_to_dispatcher(V2_to_dispatcher),
        .cdb_valid(cdb_valid), .cdb_Q(cdb_Q), .cdb_V(cdb_V), .cdb_jump(cdb_jump),
        .commit_flag_to_regfile(commit_flag_to_regfile), .rd_to_regfile(rd_to_regfile),
        .Q_to_regfile(Q_to_regfile), .V_to_regfile(V_to_regfile),
        .commit_store_to_lsb(commit_store_to_lsb), .rollback_flag(rollback_flag),
        .target_pc_to_if(target_pc_to_if)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: in-flight instructions in program order plus a per-tag result table.
    typedef struct {
        logic [4:0]  tag;
        logic [4:0]  rd;
        logic [31:0] val;
        bit          ready;
        bit          br;
        bit          st;
        bit          pj;
        bit          aj;
        logic [31:0] alt;
    } ent_t;

    ent_t        q[$];
    logic [4:0]  next_tag = 5'd1;
    bit          res_ready [17];
    logic [31:0] res_val   [17];
    bit          model_live = 1'b0;

    bit          exp_commit = 1'b0;
    logic [4:0]  exp_rd = '0;
    logic [4:0]  exp_q = '0;
    logic [31:0] exp_v = '0;
    bit          exp_store = 1'b0;
    bit          exp_rb = 1'b0;
    logic [31:0] exp_pc = '0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic expLookup(input logic [4:0] tag, output logic r, output logic [31:0] v);
        if (tag == 5'd0) begin
            r = 1'b1; v = '0;
        end else if (cdb_valid && cdb_Q == tag) begin
            r = 1'b1; v = cdb_V;
        end else if (tag <= 5'd16) begin
            r = res_ready[tag]; v = res_val[tag];
        end else begin
            r = 1'b0; v = '0;
        end
    endtask

    // Advance the model on each rising edge from the inputs the DUT also sees.
    always @(posedge clk_in) begin
        bit   rb_prev;
        bit   was_full;
        bit   committed;
        bit   mis;
        ent_t e;
        if (rst_in) begin
            q.delete();
            next_tag = 5'd1;
            for (int t = 0; t < 17; t++) begin
                res_ready[t] = 1'b0;
                res_val[t]   = '0;
            end
            exp_commit = 0; exp_rd = '0; exp_q = '0; exp_v = '0;
            exp_store = 0; exp_rb = 0; exp_pc = '0;
            model_live = 1'b1;
        end else begin
            rb_prev    = exp_rb;
            was_full   = (q.size() == 16);
            exp_commit = 0;
            exp_store  = 0;
            exp_rb     = 0;
            if (rdy_in) begin
                committed = 0;
                mis       = 0;
                if (q.size() > 0 && q[0].ready) begin
                    committed  = 1;
                    exp_commit = 1;
                    exp_rd     = q[0].rd;
                    exp_q      = q[0].tag;
                    exp_v      = q[0].val;
                    exp_store  = q[0].st;
                    mis        = q[0].br && (q[0].aj != q[0].pj);
                end
                if (mis) begin
                    exp_rb   = 1;
                    exp_pc   = q[0].alt;
                    q.delete();
                    next_tag = 5'd1;
                end else begin
                    if (cdb_valid && !rb_prev) begin
                        foreach (q[i]) begin
                            if (q[i].tag == cdb_Q) begin
                                q[i].ready = 1;
                                q[i].val   = cdb_V;
                                q[i].aj    = cdb_jump;
                                res_ready[cdb_Q] = 1'b1;
                                res_val[cdb_Q]   = cdb_V;
                            end
                        end
                    end
                    if (committed) void'(q.pop_front());
                    if (en_signal_from_dispatcher && !was_full && !rb_prev) begin
                        e.tag = next_tag; e.rd = rd_from_dispatcher; e.val = '0; e.ready = 0;
                        e.br = is_branch_from_dispatcher; e.st = is_store_from_dispatcher;
                        e.pj = pred_jump_from_dispatcher; e.aj = 0; e.alt = alt_pc_from_dispatcher;
                        q.push_back(e);
                        res_ready[next_tag] = 1'b0;
                        next_tag = (next_tag == 5'd16) ? 5'd1 : next_tag + 5'd1;
                    end
                end
            end
        end
    end

    // Compare every DUT output against the model on the falling edge.
    always @(negedge clk_in) begin
        logic        r1, r2;
        logic [31:0] v1, v2;
        if (model_live) begin
            expLookup(Q1_from_dispatcher, r1, v1);
            expLookup(Q2_from_dispatcher, r2, v2);
            checkOutput("m_Q_disp", 32'(Q_to_dispatcher), 32'(next_tag));
            checkOutput("m_full", 32'(full_to_dispatcher), 32'(q.size() == 16));
            checkOutput("m_commit", 32'(commit_flag_to_regfile), 32'(exp_commit));
            checkOutput("m_rd", 32'(rd_to_regfile), 32'(exp_rd));
            checkOutput("m_Q_reg", 32'(Q_to_regfile), 32'(exp_q));
            checkOutput("m_V_reg", V_to_regfile, exp_v);
            checkOutput("m_store", 32'(commit_store_to_lsb), 32'(exp_store));
            checkOutput("m_rollback", 32'(rollback_flag), 32'(exp_rb));
            checkOutput("m_target", target_pc_to_if, exp_pc);
            checkOutput("m_ready1", 32'(ready1_to_dispatcher), 32'(r1));
            checkOutput("m_V1", V1_to_dispatcher, v1);
            checkOutput("m_ready2", 32'(ready2_to_dispatcher), 32'(r2));
            checkOutput("m_V2", V2_to_dispatcher, v2);
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic [4:0] rd, input logic br, input logic st,
                                 input logic pj, input logic [31:0] alt, input logic cv,
                                 input logic [4:0] cq, input logic [31:0] cvv, input logic cj);
        en_signal_from_dispatcher = en;
        rd_from_dispatcher        = rd;
        is_branch_from_dispatcher = br;
        is_store_from_dispatcher  = st;
        pred_jump_from_dispatcher = pj;
        alt_pc_from_dispatcher    = alt;
        cdb_valid                 = cv;
        cdb_Q                     = cq;
        cdb_V                     = cvv;
        cdb_jump                  = cj;
        tick();
        en_signal_from_dispatcher = 1'b0;
        cdb_valid                 = 1'b0;
    endtask

    task automatic alloc(input logic [4:0] rd);
        applyStimulus(1'b1, rd, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    endtask

    task automatic cdbWrite(input logic [4:0] tag, input logic [31:0] v, input logic j);
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, tag, v, j);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    endtask

    task automatic resetDut();
        rst_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
    endtask

    initial begin
        // Reset state and single commit
        resetDut();
        checkOutput("rst_Q_disp", 32'(Q_to_dispatcher), 32'd1);
        checkOutput("rst_full", 32'(full_to_dispatcher), 32'd0);
        checkOutput("rst_commit", 32'(commit_flag_to_regfile), 32'd0);
        checkOutput("rst_rollback", 32'(rollback_flag), 32'd0);
        checkOutput("rst_V_reg", V_to_regfile, 32'd0);
        checkOutput("rst_target", target_pc_to_if, 32'd0);
        alloc(5'd5);
        checkOutput("t1_Q_disp", 32'(Q_to_dispatcher), 32'd2);
        cdbWrite(5'd1, 32'h1234, 1'b0);
        checkOutput("t1_no_commit_yet", 32'(commit_flag_to_regfile), 32'd0);
        idle();
        checkOutput("t1_commit", 32'(commit_flag_to_regfile), 32'd1);
        checkOutput("t1_rd", 32'(rd_to_regfile), 32'd5);
        checkOutput("t1_Q_reg", 32'(Q_to_regfile), 32'd1);
        checkOutput("t1_V_reg", V_to_regfile, 32'h1234);
        idle();
        checkOutput("t1_pulse_end", 32'(commit_flag_to_regfile), 32'd0);

        // Fill to capacity, overflow enable ignored, tag wraps
        resetDut();
        for (int i = 0; i < 16; i++) alloc(5'(i + 1));
        checkOutput("t2_full", 32'(full_to_dispatcher), 32'd1);
        checkOutput("t2_Q_wrap", 32'(Q_to_dispatcher), 32'd1);
        alloc(5'd31);
        checkOutput("t2_full_hold", 32'(full_to_dispatcher), 32'd1);
        checkOutput("t2_Q_hold", 32'(Q_to_dispatcher), 32'd1);
        cdbWrite(5'd1, 32'hAA, 1'b0);
        idle();
        checkOutput("t2_commit", 32'(commit_flag_to_regfile), 32'd1);
        checkOutput("t2_commit_rd", 32'(rd_to_regfile), 32'd1);
        checkOutput("t2_not_full", 32'(full_to_dispatcher), 32'd0);
        checkOutput("t2_Q_after", 32'(Q_to_dispatcher), 32'd1);
        alloc(5'd20);
        checkOutput("t2_refull", 32'(full_to_dispatcher), 32'd1);
        checkOutput("t2_Q_next", 32'(Q_to_dispatcher), 32'd2);

        // Out-of-order completion, in-order commit
        resetDut();
        alloc(5'd3);
        alloc(5'd4);
        cdbWrite(5'd2, 32'd22, 1'b0);
        checkOutput("t3_wait0", 32'(commit_flag_to_regfile), 32'd0);
        idle();
        checkOutput("t3_wait1", 32'(commit_flag_to_regfile), 32'd0);
        cdbWrite(5'd1, 32'd11, 1'b0);
        checkOutput("t3_wait2", 32'(commit_flag_to_regfile), 32'd0);
        idle();
        checkOutput("t3_c1", 32'(commit_flag_to_regfile), 32'd1);
        checkOutput("t3_c1_Q", 32'(Q_to_regfile), 32'd1);
        checkOutput("t3_c1_V", V_to_regfile, 32'd11);
        idle();
        checkOutput("t3_c2", 32'(commit_flag_to_regfile), 32'd1);
        checkOutput("t3_c2_Q", 32'(Q_to_regfile), 32'd2);
        checkOutput("t3_c2_V", V_to_regfile, 32'd22);
        checkOutput("t3_c2_rd", 32'(rd_to_regfile), 32'd4);
        idle();
        checkOutput("t3_done", 32'(commit_flag_to_regfile), 32'd0);

        // Mispredicted branch with younger entries
        resetDut();
        applyStimulus(1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 32'h100, 1'b0, 5'd0, 32'h0, 1'b0);
        alloc(5'd6);
        alloc(5'd7);
        alloc(5'd8);
        cdbWrite(5'd1, 32'h0, 1'b1);
        checkOutput("t4_no_rb_yet", 32'(rollback_flag), 32'd0);
        idle();
        checkOutput("t4_rb", 32'(rollback_flag), 32'd1);
        checkOutput("t4_target", target_pc_to_if, 32'h100);
        checkOutput("t4_Q_disp", 32'(Q_to_dispatcher), 32'd1);
        checkOutput("t4_full", 32'(full_to_dispatcher), 32'd0);
        alloc(5'd9);
        checkOutput("t4_rb_end", 32'(rollback_flag), 32'd0);
        checkOutput("t4_alloc_ignored", 32'(Q_to_dispatcher), 32'd1);
        alloc(5'd9);
        checkOutput("t4_alloc_ok", 32'(Q_to_dispatcher), 32'd2);
        applyStimulus(1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 5'd0, 32'h0, 1'b0);
        cdbWrite(5'd1, 32'd5, 1'b0);
        cdbWrite(5'd2, 32'd0, 1'b1);
        checkOutput("t4_c1", 32'(Q_to_regfile), 32'd1);
        idle();
        checkOutput("t4_good_br", 32'(Q_to_regfile), 32'd2);
        checkOutput("t4_good_no_rb", 32'(rollback_flag), 32'd0);
        checkOutput("t4_target_hold", target_pc_to_if, 32'h100);
        applyStimulus(1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        cdbWrite(5'd3, 32'd0, 1'b0);
        idle();
        checkOutput("t4_store", 32'(commit_store_to_lsb), 32'd1);
        idle();
        checkOutput("t4_store_end", 32'(commit_store_to_lsb), 32'd0);

        // Operand lookup with CDB forwarding and tag 0
        resetDut();
        alloc(5'd1);
        alloc(5'd2);
        alloc(5'd3);
        cdb_valid = 1'b1; cdb_Q = 5'd3; cdb_V = 32'd7; cdb_jump = 1'b0;
        Q1_from_dispatcher = 5'd3; Q2_from_dispatcher = 5'd0;
        #1;
        checkOutput("t5_ready1_fwd", 32'(ready1_to_dispatcher), 32'd1);
        checkOutput("t5_V1_fwd", V1_to_dispatcher, 32'd7);
        checkOutput("t5_ready2_zero", 32'(ready2_to_dispatcher), 32'd1);
        checkOutput("t5_V2_zero", V2_to_dispatcher, 32'd0);
        tick();
        cdb_valid = 1'b0;
        Q2_from_dispatcher = 5'd2;
        #1;
        checkOutput("t5_ready1_entry", 32'(ready1_to_dispatcher), 32'd1);
        checkOutput("t5_V1_entry", V1_to_dispatcher, 32'd7);
        checkOutput("t5_ready2_pending", 32'(ready2_to_dispatcher), 32'd0);
        tick();
        Q1_from_dispatcher = 5'd0; Q2_from_dispatcher = 5'd0;

        // rdy_in low freezes state and clears pulses
        resetDut();
        alloc(5'd10);
        cdbWrite(5'd1, 32'h55, 1'b0);
        rdy_in = 1'b0;
        idle();
        checkOutput("t6_frozen", 32'(commit_flag_to_regfile), 32'd0);
        alloc(5'd11);
        checkOutput("t6_frozen2", 32'(commit_flag_to_regfile), 32'd0);
        checkOutput("t6_Q_frozen", 32'(Q_to_dispatcher), 32'd2);
        rdy_in = 1'b1;
        idle();
        checkOutput("t6_commit", 32'(commit_flag_to_regfile), 32'd1);
        checkOutput("t6_V", V_to_regfile, 32'h55);
        rdy_in = 1'b0;
        idle();
        checkOutput("t6_pulse_clear", 32'(commit_flag_to_regfile), 32'd0);
        rdy_in = 1'b1;

        // Reset in the middle of activity
        alloc(5'd1);
        alloc(5'd2);
        cdbWrite(5'd2, 32'd9, 1'b0);
        rst_in = 1'b1;
        cdbWrite(5'd3, 32'd4, 1'b0);
        rst_in = 1'b0;
        checkOutput("t7_Q_disp", 32'(Q_to_dispatcher), 32'd1);
        checkOutput("t7_commit", 32'(commit_flag_to_regfile), 32'd0);
        checkOutput("t7_V_reg", V_to_regfile, 32'd0);
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order retirement stage of the out-of-order RISC-V core. Sits between the dispatcher/CDB and the register file. Holds up to ROB_SIZE in-flight instructions in a circular queue and hands out 5-bit rename tags to the dispatcher. Collects results from the CDB and commits one instruction per cycle in program order to the register file. On a mispredicted branch at head it drives the global rollback.

## Interface
- ROB_SIZE, 16, number of entries; tag = index+1, so tags run 1..16 and tag 0 means "no producer"
- clk_in  input  1  clock; single clock domain
- rst_in  input  1  reset, synchronous, active-high
- rdy_in  input  1  global enable; low freezes all state
- en_signal_from_dispatcher  input  1  allocate an entry this cycle
- rd_from_dispatcher  input  5  destination register (0 = none)
- is_branch_from_dispatcher  input  1  entry is a conditional branch
- is_store_from_dispatcher  input  1  entry is a store
- pred_jump_from_dispatcher  input  1  predicted taken
- alt_pc_from_dispatcher  input  32  PC to restart at if the prediction is wrong
- Q_to_dispatcher  output  5  tag that the next allocation receives (tail index+1)
- full_to_dispatcher  output  1  count == ROB_SIZE
- Q1_from_dispatcher, Q2_from_dispatcher  input  5 each  operand tags to look up
- ready1_to_dispatcher, ready2_to_dispatcher  output  1 each  value for that tag is available
- V1_to_dispatcher, V2_to_dispatcher  output  32 each  that value
- cdb_valid  input  1  result broadcast valid
- cdb_Q  input  5  tag of the producing entry
- cdb_V  input  32  result value
- cdb_jump  input  1  actual branch outcome
- commit_flag_to_regfile  output  1  one-cycle commit pulse
- rd_to_regfile  output  5  destination register of the commit
- Q_to_regfile  output  5  tag of the commit
- V_to_regfile  output  32  value of the commit
- commit_store_to_lsb  output  1  one-cycle pulse: store at head retired
- rollback_flag  output  1  one-cycle flush broadcast
- target_pc_to_if  output  32  restart PC, valid while rollback_flag is high

## Operation
- Entry fields: busy, ready, rd, value, is_branch, is_store, pred_jump, actual_jump, alt_pc.
- State: head and tail pointers (mod ROB_SIZE) and count (0..ROB_SIZE).
- Allocate when en_signal_from_dispatcher is high and not full:
  - write the entry at tail with busy=1, ready=0;
  - tail++, count++.
  - The dispatcher never asserts en while full; if it does, the ROB ignores it.
- Writeback: when cdb_valid is high and entry cdb_Q is busy, set ready=1 and latch value and actual_jump.
- Operand lookup is combinational. For tag Qx≠0, readyx = entry ready, or (cdb_valid && cdb_Q == Qx). Vx comes from the CDB on a match, otherwise from the entry. For tag 0, ready=1 and V=0.
- Commit: when the head entry is busy and ready, in one cycle:
  - register commit_flag_to_regfile=1 with rd, Q = head+1 and value;
  - pulse commit_store_to_lsb if the entry is a store;
  - free the entry, head++, count--.
- Mispredict: if the committing entry is a branch with actual_jump ≠ pred_jump, the ROB additionally registers rollback_flag=1 and target_pc_to_if=alt_pc. In that same edge it clears all busy bits and sets head=tail=count=0.
- While rollback_flag is high, allocations and CDB writes are ignored.
- Allocation and commit in the same cycle leave count unchanged. A CDB write to the head in the same cycle is not committed until the next cycle.

## Timing
- Reset: all outputs 0, head=tail=count=0, all busy=0. Q_to_dispatcher=1, full=0.
- An allocation becomes visible one cycle after its enable edge.
- Minimum CDB-to-commit latency is 1 cycle: the CDB writes at edge N, commit outputs are high after edge N+1.
- Commit, store and rollback pulses last exactly one cycle. They are cleared on any cycle with no commit, including cycles with rdy_in low.
- Wrap-around: pointers go ROB_SIZE-1 → 0, tags go 16 → 1.
- Reset asserted mid-operation overrides everything on that edge.

## Structure
- Shared package: ROB_SIZE, tag width (5), and the NO_TAG=0 constant.
- Flat single module; no sub-module needed. Entry arrays use plain reg arrays.

## Test plan
- Reset, then allocate rd=5; CDB writes Q=1 V=0x1234 → next cycle commit_flag=1, rd=5, Q=1, V=0x1234.
- Allocate 16 entries → full=1 and a 17th enable is ignored. Commit one → full=0 and Q_to_dispatcher=1 (wrap).
- CDB completes Q=2 before Q=1 → no commit until Q=1 is written; then Q=1 and Q=2 commit on consecutive cycles.
- Branch predicted 0, cdb_jump=1, alt_pc=0x100, with 3 younger entries → rollback_flag=1, target_pc=0x100, count=0, next Q_to_dispatcher=1.
- Query Q1=3 in the same cycle that the CDB broadcasts Q=3 V=7 → ready1=1, V1=7. Query Q2=0 → ready2=1, V2=0.
- Hold rdy_in=0 while the head is ready → no commit and state unchanged. Raise rdy_in → commit follows on the next edge.
